// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int          STALL_BUS        = 6;
  localparam logic        STOP             = 1'b1;
  localparam int          IF_TO_ID_WD      = 33;
  localparam int          BR_WD            = 33;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef struct packed {
    logic        br_e;
    logic [31:0] br_addr;
  } br_bus_t;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/if_fetch_stage_pc_sel.sv
// Next-PC priority mux: flush, then live branch, then held branch, then sequential.
module if_fetch_stage_pc_sel (
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_e,
  input  logic [31:0] br_addr,
  input  logic        pend_v,
  input  logic [31:0] pend_addr,
  input  logic [31:0] pc,
  output logic [31:0] next_pc
);

  // Priority selection of the next fetch address
  always_comb begin
    next_pc = pc + 32'd4;
    if (flush) begin
      next_pc = flush_pc;
    end else if (br_e) begin
      next_pc = br_addr;
    end else if (pend_v) begin
      next_pc = pend_addr;
    end else begin
      next_pc = pc + 32'd4;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM and
// remembers a branch redirect that lands while fetch is stalled.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          STALL_W  = STALL_BUS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic [BR_WD-1:0]       br_bus,
  input  logic                   flush,
  input  logic [31:0]            flush_pc,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   fetch_adel,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata
);

  logic [31:0] pc_r;
  logic        ce_r;
  logic        pend_v_r;
  logic [31:0] pend_addr_r;

  br_bus_t     br_s;
  logic        hold_s;
  logic [31:0] next_pc_s;
  logic        unused_stall_s;

  assign br_s           = br_bus_t'(br_bus);
  assign hold_s         = (stall[0] == STOP);
  // Only bit 0 concerns fetch; the other stall bits belong to later stages.
  assign unused_stall_s = ^stall;

  if_fetch_stage_pc_sel u_pc_sel (
    .flush     (flush),
    .flush_pc  (flush_pc),
    .br_e      (br_s.br_e),
    .br_addr   (br_s.br_addr),
    .pend_v    (pend_v_r),
    .pend_addr (pend_addr_r),
    .pc        (pc_r),
    .next_pc   (next_pc_s)
  );

  // PC and fetch-valid register; flush overrides any stall
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC - 32'd4;
      ce_r <= 1'b0;
    end else if (flush || !hold_s) begin
      pc_r <= next_pc_s;
      ce_r <= 1'b1;
    end
  end

  // Held branch target: captured under stall, dropped once fetch moves or flushes
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_r    <= 1'b0;
      pend_addr_r <= 32'd0;
    end else if (flush || !hold_s) begin
      pend_v_r    <= 1'b0;
    end else if (br_s.br_e) begin
      pend_v_r    <= 1'b1;
      pend_addr_r <= br_s.br_addr;
    end
  end

  assign if_to_id_bus    = {ce_r, pc_r};
  assign inst_sram_addr  = pc_r;
  // A misaligned PC raises AdEL instead of reaching the SRAM.
  assign inst_sram_en    = ce_r & ~pc_misaligned(pc_r);
  assign fetch_adel      = ce_r & pc_misaligned(pc_r);
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed vector table followed by
// randomized traffic checked against a behavioural fetch model.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic        flush;
  logic [31:0] flush_pc;
  logic [32:0] if_to_id_bus;
  logic        fetch_adel;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .if_to_id_bus    (if_to_id_bus),
    .fetch_adel      (fetch_adel),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall0;
    logic        br_e;
    logic [31:0] br_addr;
    logic        flush;
    logic [31:0] flush_pc;
    logic        exp_ce;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: fetch address, valid flag and at most one remembered redirect.
  logic [31:0] m_pc;
  logic        m_ce;
  logic [31:0] m_pend[$];

  task automatic add_vec(input logic r, input logic s, input logic be, input logic [31:0] ba,
                         input logic fl, input logic [31:0] fp, input logic ec, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.stall0 = s; v.br_e = be; v.br_addr = ba;
    v.flush = fl; v.flush_pc = fp; v.exp_ce = ec; v.exp_pc = ep;
    vecs.push_back(v);
  endtask

  task automatic check_out(input string tag, input int idx, input logic exp_ce, input logic [31:0] exp_pc);
    logic exp_en;
    logic exp_adel;
    exp_adel = exp_ce && (exp_pc[1:0] != 2'b00);
    exp_en   = exp_ce && (exp_pc[1:0] == 2'b00);
    n_checks++;
    if (if_to_id_bus !== {exp_ce, exp_pc}) begin
      n_errors++;
      $display("FAIL %s[%0d] if_to_id_bus got %h want %h", tag, idx, if_to_id_bus, {exp_ce, exp_pc});
    end
    n_checks++;
    if (inst_sram_addr !== exp_pc) begin
      n_errors++;
      $display("FAIL %s[%0d] inst_sram_addr got %h want %h", tag, idx, inst_sram_addr, exp_pc);
    end
    n_checks++;
    if (inst_sram_en !== exp_en) begin
      n_errors++;
      $display("FAIL %s[%0d] inst_sram_en got %b want %b", tag, idx, inst_sram_en, exp_en);
    end
    n_checks++;
    if (fetch_adel !== exp_adel) begin
      n_errors++;
      $display("FAIL %s[%0d] fetch_adel got %b want %b", tag, idx, fetch_adel, exp_adel);
    end
    n_checks++;
    if (inst_sram_wen !== 4'b0000 || inst_sram_wdata !== 32'd0) begin
      n_errors++;
      $display("FAIL %s[%0d] sram write ties got wen=%h wdata=%h want 0/0", tag, idx, inst_sram_wen, inst_sram_wdata);
    end
  endtask

  task automatic model_step(input logic r, input logic s0, input logic be, input logic [31:0] ba,
                            input logic fl, input logic [31:0] fp);
    if (r) begin
      m_pc = RST_PC - 32'd4;
      m_ce = 1'b0;
      m_pend.delete();
    end else if (fl) begin
      m_pc = fp;
      m_ce = 1'b1;
      m_pend.delete();
    end else if (!s0) begin
      if (be)                    m_pc = ba;
      else if (m_pend.size() > 0) m_pc = m_pend[0];
      else                       m_pc = m_pc + 32'd4;
      m_ce = 1'b1;
      m_pend.delete();
    end else if (be) begin
      m_pend.delete();
      m_pend.push_back(ba);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 6'd0; br_bus = 33'd0; flush = 1'b0; flush_pc = 32'd0;

    // reset release and sequential fetch
    add_vec(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'hBFBF_FFFC);
    add_vec(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'hBFBF_FFFC);
    add_vec(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'hBFBF_FFFC);
    add_vec(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0000);
    add_vec(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0004);
    add_vec(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0008);
    add_vec(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_000C);
    add_vec(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0010);
    // taken branch while 0x10 (delay slot) is in fetch
    add_vec(1'b0, 1'b0, 1'b1, 32'hBFC0_0100, 1'b0, 32'd0, 1'b1, 32'hBFC0_0100);
    add_vec(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0104);
    // branch under a 3-cycle stall
    add_vec(1'b0, 1'b1, 1'b1, 32'hBFC0_0200, 1'b0, 32'd0, 1'b1, 32'hBFC0_0104);
    add_vec(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0104);
    add_vec(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0104);
    add_vec(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0200);
    add_vec(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0204);
    // flush beats branch and stall, and leaves nothing pending
    add_vec(1'b0, 1'b1, 1'b1, 32'hBFC0_0500, 1'b1, 32'hBFC0_0380, 1'b1, 32'hBFC0_0380);
    add_vec(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0380);
    add_vec(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0384);
    // misaligned branch target
    add_vec(1'b0, 1'b0, 1'b1, 32'hBFC0_0102, 1'b0, 32'd0, 1'b1, 32'hBFC0_0102);
    // wrap
    add_vec(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC);
    add_vec(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0000);
    add_vec(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0004);
    // reset while a branch is pending discards it
    add_vec(1'b0, 1'b1, 1'b1, 32'hBFC0_0700, 1'b0, 32'd0, 1'b1, 32'h0000_0004);
    add_vec(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'hBFBF_FFFC);
    add_vec(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0000);
    add_vec(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0004);
    // live branch supersedes a pending one
    add_vec(1'b0, 1'b1, 1'b1, 32'hBFC0_0800, 1'b0, 32'd0, 1'b1, 32'hBFC0_0004);
    add_vec(1'b0, 1'b0, 1'b1, 32'hBFC0_0900, 1'b0, 32'd0, 1'b1, 32'hBFC0_0900);
    add_vec(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0904);

    for (int i = 0; i < vecs.size(); i++) begin
      rst      = vecs[i].rst;
      stall    = {5'b00000, vecs[i].stall0};
      br_bus   = {vecs[i].br_e, vecs[i].br_addr};
      flush    = vecs[i].flush;
      flush_pc = vecs[i].flush_pc;
      @(posedge clk);
      #1;
      check_out("vec", i, vecs[i].exp_ce, vecs[i].exp_pc);
    end

    // randomized traffic against the model, starting from a reset
    for (int i = 0; i < 2000; i++) begin
      logic        r, s0, be, fl;
      logic [31:0] ba, fp;
      r  = (i == 0) || ($urandom_range(63) == 0);
      s0 = ($urandom_range(2) == 0);
      be = ($urandom_range(3) == 0);
      fl = ($urandom_range(15) == 0);
      ba = $urandom;
      if ($urandom_range(7) != 0) ba[1:0] = 2'b00;
      fp = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : {$urandom} & 32'hFFFF_FFFC;
      rst      = r;
      stall    = {6'($urandom_range(31)) << 1} | {5'b00000, s0};
      br_bus   = {be, ba};
      flush    = fl;
      flush_pc = fp;
      model_step(r, s0, be, ba, fl, fp);
      @(posedge clk);
      #1;
      check_out("rand", i, m_ce, m_pc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
